// File: rtl/cmac_stats_pkg.sv
// Shared widths, default frame limits and frame classes for the CMAC RX statistics path.
package cmac_stats_pkg;
  localparam int KEEP_W        = 64;
  localparam int LEN_W         = 16;
  localparam int BEAT_BYTES_W  = 7;
  localparam int DEF_MIN_BYTES = 60;
  localparam int DEF_MAX_BYTES = 1514;

  typedef enum logic [1:0] {
    GOOD,
    BAD_FCS,
    RUNT,
    OVERSIZE
  } frame_class_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry AXI-Stream register slice, 1-cycle latency, full throughput.
// s_rdy is registered: it drops only with both entries full and returns the cycle after a drain.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_vld,
  output logic         s_rdy,
  input  logic [W-1:0] s_dat,
  output logic         m_vld,
  input  logic         m_rdy,
  output logic [W-1:0] m_dat
);
  logic         skid_vld;
  logic         skid_vld_nxt;
  logic [W-1:0] skid_dat;
  logic         s_hs;
  logic         load_main;

  assign s_hs      = s_vld & s_rdy;
  assign load_main = ~m_vld | m_rdy;

  // A held skid entry always moves to the output before new input is taken.
  always_comb begin
    skid_vld_nxt = load_main ? 1'b0 : (skid_vld | s_hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rdy    <= 1'b0;
      m_vld    <= 1'b0;
      m_dat    <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else begin
      s_rdy    <= ~skid_vld_nxt;
      skid_vld <= skid_vld_nxt;
      if (load_main) begin
        m_vld <= skid_vld | s_hs;
        m_dat <= skid_vld ? skid_dat : s_dat;
      end else if (s_hs) begin
        skid_dat <= s_dat;
      end
    end
  end
endmodule

// File: rtl/cmac_rx_monitor.sv
// CMAC RX monitor: passes the stream through a skid buffer (1 cycle, m-side backpressure
// stalls s via registered tready) and keeps saturating per-class frame/byte counters with snapshot.
module cmac_rx_monitor
  import cmac_stats_pkg::*;
#(
  parameter int DATA_W    = KEEP_W * 8,
  parameter int CNT_W     = 48,
  parameter int MIN_BYTES = DEF_MIN_BYTES,
  parameter int MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic                user_clk,
  input  logic                user_resetn,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic                snap,
  output logic                snap_valid,
  output logic [CNT_W-1:0]    stat_good,
  output logic [CNT_W-1:0]    stat_bad_fcs,
  output logic [CNT_W-1:0]    stat_runt,
  output logic [CNT_W-1:0]    stat_oversize,
  output logic [CNT_W-1:0]    stat_bytes
);
  localparam int KW = DATA_W / 8;
  localparam int PW = DATA_W + KW + 2;

  typedef enum logic {IDLE, FRAME} state_t;

  logic [PW-1:0]           m_payload;
  logic                    s_hs;
  logic                    frame_done;
  logic [BEAT_BYTES_W-1:0] beat_bytes;
  logic [LEN_W:0]          len_sum;
  logic [LEN_W-1:0]        len_acc;
  logic [LEN_W-1:0]        frame_len;
  state_t                  state;
  frame_class_t            cls;
  logic [CNT_W-1:0]        good_cnt, bad_cnt, runt_cnt, over_cnt, byte_cnt;
  logic [CNT_W-1:0]        good_nxt, bad_nxt, runt_nxt, over_nxt, byte_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  axis_skid_buffer #(.W(PW)) u_skid (
    .clk   (user_clk),
    .rst_n (user_resetn),
    .s_vld (s_axis_tvalid),
    .s_rdy (s_axis_tready),
    .s_dat ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
    .m_vld (m_axis_tvalid),
    .m_rdy (m_axis_tready),
    .m_dat (m_payload)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = m_payload;

  assign s_hs       = s_axis_tvalid & s_axis_tready;
  assign frame_done = s_hs & s_axis_tlast;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KW; i++) begin
      beat_bytes = beat_bytes + BEAT_BYTES_W'(s_axis_tkeep[i]);
    end
    len_sum   = {1'b0, (state == FRAME) ? len_acc : LEN_W'(0)} + (LEN_W+1)'(beat_bytes);
    frame_len = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    if (s_axis_tuser)                        cls = BAD_FCS;
    else if (frame_len < LEN_W'(MIN_BYTES))  cls = RUNT;
    else if (frame_len > LEN_W'(MAX_BYTES))  cls = OVERSIZE;
    else                                     cls = GOOD;
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      state   <= IDLE;
      len_acc <= '0;
    end else if (s_hs) begin
      if (s_axis_tlast) begin
        state   <= IDLE;
        len_acc <= '0;
      end else begin
        state   <= FRAME;
        len_acc <= frame_len;
      end
    end
  end

  always_comb begin
    good_nxt = (frame_done && cls == GOOD)     ? sat_add(good_cnt, LEN_W'(1)) : good_cnt;
    bad_nxt  = (frame_done && cls == BAD_FCS)  ? sat_add(bad_cnt,  LEN_W'(1)) : bad_cnt;
    runt_nxt = (frame_done && cls == RUNT)     ? sat_add(runt_cnt, LEN_W'(1)) : runt_cnt;
    over_nxt = (frame_done && cls == OVERSIZE) ? sat_add(over_cnt, LEN_W'(1)) : over_cnt;
    byte_nxt = (frame_done && cls == GOOD)     ? sat_add(byte_cnt, frame_len) : byte_cnt;
  end

  // The snapshot takes the post-update values so a frame closing in the snap cycle lands in it.
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      good_cnt      <= '0;
      bad_cnt       <= '0;
      runt_cnt      <= '0;
      over_cnt      <= '0;
      byte_cnt      <= '0;
      stat_good     <= '0;
      stat_bad_fcs  <= '0;
      stat_runt     <= '0;
      stat_oversize <= '0;
      stat_bytes    <= '0;
      snap_valid    <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) begin
        stat_good     <= good_nxt;
        stat_bad_fcs  <= bad_nxt;
        stat_runt     <= runt_nxt;
        stat_oversize <= over_nxt;
        stat_bytes    <= byte_nxt;
        good_cnt      <= '0;
        bad_cnt       <= '0;
        runt_cnt      <= '0;
        over_cnt      <= '0;
        byte_cnt      <= '0;
      end else begin
        good_cnt <= good_nxt;
        bad_cnt  <= bad_nxt;
        runt_cnt <= runt_nxt;
        over_cnt <= over_nxt;
        byte_cnt <= byte_nxt;
      end
    end
  end
endmodule

// File: tb/tb_cmac_rx_monitor.sv
// Directed and randomized-stall bench for cmac_rx_monitor with a beat scoreboard and stats model.
module tb_cmac_rx_monitor;
  localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          user_clk = 1'b0;
  logic          user_resetn;
  logic [511:0]  s_axis_tdata = '0;
  logic [63:0]   s_axis_tkeep = '0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [511:0]  m_axis_tdata;
  logic [63:0]   m_axis_tkeep;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          snap = 1'b0;
  logic          snap_valid;
  logic [47:0]   stat_good, stat_bad_fcs, stat_runt, stat_oversize, stat_bytes;

  typedef logic [577:0] beat_t;
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_in = 0;
  int    n_out = 0;
  int    since_rst = 0;
  bit    rnd_stall = 1'b0;

  always #5 user_clk = ~user_clk;

  cmac_rx_monitor #(.DATA_W(512), .CNT_W(48), .MIN_BYTES(60), .MAX_BYTES(1514)) dut (
    .user_clk      (user_clk),
    .user_resetn   (user_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .snap          (snap),
    .snap_valid    (snap_valid),
    .stat_good     (stat_good),
    .stat_bad_fcs  (stat_bad_fcs),
    .stat_runt     (stat_runt),
    .stat_oversize (stat_oversize),
    .stat_bytes    (stat_bytes)
  );

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard and skid occupancy model, sampled on the falling edge.
  always @(negedge user_clk) begin
    if (!user_resetn) begin
      exp_q.delete();
      n_in      = 0;
      n_out     = 0;
      since_rst = 0;
      check("rst_m_vld", m_axis_tvalid, 0);
      check("rst_s_rdy", s_axis_tready, 0);
    end else begin
      since_rst++;
      if (since_rst >= 2) check("s_rdy_room", s_axis_tready, (n_in - n_out) < 2);
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
        n_in++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge user_clk);
      #1;
      m_axis_tready = rnd_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic u,
                           input logic l, input logic sn);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    snap          = sn;
    for (int n = 0; ; n++) begin
      @(negedge user_clk);
      if (s_axis_tready) break;
      if (n == 2000) begin
        check("s_rdy_timeout", 0, 1);
        break;
      end
    end
    @(posedge user_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    snap          = 1'b0;
  endtask

  // Full-keep leading beats, given keep on the last beat.
  task automatic send_frame(input int nb, input logic [63:0] last_keep, input logic u,
                            input logic sn);
    for (int b = 0; b < nb - 1; b++) send_beat(rnd512(), KEEP_ALL, 1'b0, 1'b0, 1'b0);
    send_beat(rnd512(), last_keep, u, 1'b1, sn);
  endtask

  task automatic check_stats(input string tag, input logic [47:0] g, input logic [47:0] b,
                             input logic [47:0] r, input logic [47:0] o, input logic [47:0] by);
    check({tag, "_snap_valid"}, snap_valid, 1);
    check({tag, "_good"}, stat_good, g);
    check({tag, "_bad_fcs"}, stat_bad_fcs, b);
    check({tag, "_runt"}, stat_runt, r);
    check({tag, "_oversize"}, stat_oversize, o);
    check({tag, "_bytes"}, stat_bytes, by);
    @(posedge user_clk);
    #1;
    check({tag, "_snap_valid_clr"}, snap_valid, 0);
  endtask

  task automatic do_snap(input string tag, input logic [47:0] g, input logic [47:0] b,
                         input logic [47:0] r, input logic [47:0] o, input logic [47:0] by);
    snap = 1'b1;
    @(posedge user_clk);
    #1;
    snap = 1'b0;
    check_stats(tag, g, b, r, o, by);
  endtask

  task automatic do_reset();
    user_resetn   = 1'b0;
    s_axis_tvalid = 1'b0;
    snap          = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_snap_valid", snap_valid, 0);
    check("rst_stat_good", stat_good, 0);
    check("rst_stat_bytes", stat_bytes, 0);
    user_resetn = 1'b1;
    @(posedge user_clk);
    #1;
    check("rdy_after_rst", s_axis_tready, 1);
  endtask

  initial begin
    logic [47:0] mg, mb, mr, mo, mby;
    logic [63:0] k;
    int          nb, len;
    logic        u;

    user_resetn = 1'b1;
    #1;
    do_reset();

    // Single 64-byte frame, visible on m one cycle after its handshake.
    send_frame(1, KEEP_ALL, 1'b0, 1'b0);
    check("lat_m_vld", m_axis_tvalid, 1);
    check("stat_hold_before_snap", stat_good, 0);
    do_snap("f64", 1, 0, 0, 0, 64);

    // 78 B good, 28 B runt, 1536 B oversize.
    send_frame(2, 64'h3FFF, 1'b0, 1'b0);
    send_frame(1, 64'h0FFF_FFFF, 1'b0, 1'b0);
    send_frame(24, KEEP_ALL, 1'b0, 1'b0);
    do_snap("mix", 1, 0, 1, 1, 78);

    // 40 B with bad FCS: bad_fcs wins over runt.
    send_frame(1, 64'h00FF_FFFF_FFFF, 1'b1, 1'b0);
    do_snap("fcs_prio", 0, 1, 0, 0, 0);

    // 100 B frame closing in the snap cycle, then an empty snapshot.
    send_frame(2, 64'h0F_FFFF_FFFF, 1'b0, 1'b1);
    check_stats("snap_same", 1, 0, 0, 0, 100);
    do_snap("snap_empty", 0, 0, 0, 0, 0);

    // Random frames under random m-side stalls.
    mg = '0; mb = '0; mr = '0; mo = '0; mby = '0;
    rnd_stall = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      nb  = $urandom_range(1, 30);
      u   = ($urandom_range(0, 3) == 0);
      len = 0;
      for (int b = 0; b < nb; b++) begin
        k = ($urandom_range(0, 3) == 0 || b == nb - 1) ? {$urandom, $urandom} : KEEP_ALL;
        len += $countones(k);
        send_beat(rnd512(), k, (b == nb - 1) ? u : 1'b0, b == nb - 1, 1'b0);
      end
      if (u)               mb++;
      else if (len < 60)   mr++;
      else if (len > 1514) mo++;
      else begin
        mg++;
        mby += 48'(len);
      end
    end
    rnd_stall = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge user_clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
    @(posedge user_clk);
    #1;
    do_snap("rand", mg, mb, mr, mo, mby);

    // Reset in the middle of a frame; the partial frame must leave no trace.
    send_beat(rnd512(), KEEP_ALL, 1'b0, 1'b0, 1'b0);
    send_beat(rnd512(), KEEP_ALL, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_frame(1, KEEP_ALL, 1'b0, 1'b0);
    repeat (2) @(posedge user_clk);
    #1;
    do_snap("post_rst", 1, 0, 0, 0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmac_rx_monitor.md
# cmac_rx_monitor

Per-port receive monitor placed in the user clock domain, directly downstream of the CMAC RX clock-domain-crossing FIFO and ahead of user packet logic. It passes the RX AXI-Stream through a one-cycle register slice unchanged. It classifies every frame as good, bad-FCS, runt or oversize, and keeps saturating frame and byte counters. A snapshot pulse copies the counters to stable output registers and clears the live counters.

## Interface
- DATA_W, 512: tdata width in bits; tkeep is DATA_W/8 bits.
- CNT_W, 48: width of every statistics counter.
- MIN_BYTES, 60: smallest legal frame length in bytes (FCS already stripped).
- MAX_BYTES, 1514: largest legal frame length in bytes.
- user_clk  in  1  sole clock.
- user_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata/tkeep/tuser/tlast/tvalid  in  512/64/1/1/1  RX stream from the CDC FIFO; tuser=1 on the last beat marks a bad FCS.
- s_axis_tready  out  1  ready to the CDC FIFO.
- m_axis_tdata/tkeep/tuser/tlast/tvalid  out  512/64/1/1/1  RX stream to the user.
- m_axis_tready  in  1  ready from the user.
- snap  in  1  single-cycle snapshot request.
- snap_valid  out  1  one-cycle pulse when the stat_* outputs have been updated.
- stat_good, stat_bad_fcs, stat_runt, stat_oversize  out  CNT_W each  frame counts from the last snapshot.
- stat_bytes  out  CNT_W  total bytes of good frames from the last snapshot.

## Operation
- Pass-through
  - A 2-entry skid buffer carries tdata, tkeep, tuser and tlast bit-exactly.
  - Frames are never modified, dropped or reordered.
- Length accumulation
  - On each s-side handshake (s_axis_tvalid & s_axis_tready), beat_bytes = popcount(s_axis_tkeep), 0..64, 7 bits.
  - len_acc is 16 bits and saturates at 0xFFFF.
  - On the tlast beat, frame_len = len_acc + beat_bytes (saturating), and len_acc resets to 0.
- FSM, reset state IDLE:
  - IDLE → FRAME on a non-last handshake.
  - FRAME → IDLE on a tlast handshake.
  - A tlast handshake in IDLE is a single-beat frame.
  - The state is reported only through its effect on len_acc.
- Classification at the tlast handshake, in priority order. Exactly one class per frame:
  - tuser=1 → bad_fcs
  - else frame_len < MIN_BYTES → runt
  - else frame_len > MAX_BYTES → oversize
  - else good; stat_bytes also adds frame_len.
- Live counters
  - Each is CNT_W wide and saturates at all-ones; there is no wrap.
  - Bytes and frames are counted even if the payload is later stalled at the m side.
- Snapshot
  - On snap=1, every stat_* register loads the live counter's next value, including any frame classified in that same cycle.
  - In the same edge, each live counter clears to 0.
  - A frame ending in the snap cycle therefore appears in the snapshot and is not double-counted.
  - A snap asserted on consecutive cycles yields consecutive snapshots; the second holds only the frames of the intervening cycle.
- Reset mid-frame discards the partial frame. No class is counted for it, and the first frame after reset is measured from its first beat.

## Timing
- Reset values:
  - m_axis_tvalid=0 and s_axis_tready=0 while reset is asserted.
  - s_axis_tready=1 from the first clock after release.
  - All counters, stat_* and snap_valid are 0; len_acc is 0; the FSM is in IDLE.
- Data path
  - Latency is 1 cycle from the s handshake to m_axis_tvalid.
  - Sustained throughput is 1 beat/cycle when m_axis_tready=1.
  - s_axis_tready is registered: it falls only when both skid entries are full and rises the cycle after an m-side drain.
  - m_axis_* stays stable while m_axis_tvalid=1 and m_axis_tready=0.
- Stats path
  - Live counters update on the edge after the tlast handshake.
  - snap_valid pulses, and stat_* change, on the edge after snap; stat_* hold until the next snap.

## Structure
- Package cmac_stats_pkg holds:
  - KEEP_W = 64, LEN_W = 16, BEAT_BYTES_W = 7.
  - Default MIN/MAX frame constants.
  - The frame-class enum: GOOD, BAD_FCS, RUNT, OVERSIZE.
- Sub-module axis_skid_buffer is the generic 2-entry AXI-Stream register slice. It is parameterized on payload width and is reused elsewhere on the CMAC paths.
- The top level contains the popcount, length FSM, classifier, counters and snapshot logic.

## Test plan
- Reset, then one 64-byte frame (one beat, tkeep all-ones, tuser=0), then snap → the frame appears on m one cycle later, bit-exact; snap_valid pulses; stat_good=1, stat_bytes=64, other counters 0.
- Three frames: 2 beats with last tkeep=0x3FFF (78 B, good); 1 beat tkeep=0x0FFF_FFFF (28 B, runt); 24 beats all full (1536 B, oversize) → after snap: good=1, runt=1, oversize=1, bytes=78.
- A 40-byte frame with tuser=1 → bad_fcs=1 and runt=0, confirming priority.
- Frame tlast in the same cycle as snap → that frame is in the snapshot; a second snap with no traffic gives all zeros.
- Random m_axis_tready stalls over 1000 random frames → output stream equals input; no beats lost or duplicated; s_axis_tready never drops while the skid buffer has room.
- Reset asserted mid-frame, then a full 64-byte frame → no class is counted for the partial frame; after snap, stat_good=1, stat_bytes=64.
